idu_hazard_ctrl: RTL

- Issue controller for the ID/EX pipeline register; drives its `stall_flag` bus (`CU_STALL`, `CU_FLUSH` bits).
- Keeps a 32-entry register scoreboard for long-latency ops (load, mul, div) and detects RAW, WAW and outstanding-limit hazards.
- Serializes CSR/fence instructions and sequences multi-cycle flushes on redirect.
- Sits between the decoder outputs, the EXU/WB completion signals and the ID/EX pipe.

---
 rtl/idu_hazard_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/idu_hazard_ctrl.sv
// idu_hazard_ctrl: issue controller for the ID/EX pipeline register.
// Tracks long-latency ops (load/mul/div) in a 32-entry scoreboard and stalls on
// RAW, WAW and outstanding-limit hazards. It drains the scoreboard before a
// serializing instruction (CSR/fence) issues, and holds CU_FLUSH for
// FLUSH_CYCLES cycles on each redirect.
// Optional statistics counters are built only when HAZARD_CTRL_STAT_EN is defined.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 3
`endif
`ifndef CU_STALL
`define CU_STALL 0
`endif
`ifndef CU_FLUSH
`define CU_FLUSH 1
`endif

module idu_hazard_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FLUSH_CYCLES    = 2,
  parameter int STAT_W          = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid_i,
  input  logic [`REG_ADDR_WIDTH-1:0] id_reg1_raddr_i,
  input  logic [`REG_ADDR_WIDTH-1:0] id_reg2_raddr_i,
  input  logic                       id_rs1_re_i,
  input  logic                       id_rs2_re_i,
  input  logic                       id_reg_we_i,
  input  logic [`REG_ADDR_WIDTH-1:0] id_reg_waddr_i,
  input  logic                       id_long_op_i,
  input  logic                       id_serialize_i,
  input  logic                       ex_busy_i,
  input  logic                       wb_long_we_i,
  input  logic [`REG_ADDR_WIDTH-1:0] wb_long_waddr_i,
  input  logic                       flush_req_i,
  output logic [`CU_BUS_WIDTH-1:0]   stall_flag_o,
  output logic                       issue_o,
  output logic                       sb_busy_o,
  output logic [STAT_W-1:0]          stat_stall_cnt_o,
  output logic [STAT_W-1:0]          stat_flush_cnt_o
);

  localparam int OUT_W  = 4;
  localparam int FCNT_W = 4;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [OUT_W-1:0]  MAX_OUT      = OUT_W'(MAX_OUTSTANDING);
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [FCNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]       pending_q, pending_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic              sb_busy_q, sb_busy_d;

  logic raw, waw, full, hazard;
  logic stall, flush, issue;
  logic inc, dec;
  logic [31:0] set_mask, clr_mask;

  // Hazard terms come from the registered scoreboard only, so a dependent in
  // the write-back cycle still stalls once (no bypass of the clear).
  always_comb begin
    raw    = (id_rs1_re_i && (id_reg1_raddr_i != '0) && pending_q[id_reg1_raddr_i]) ||
             (id_rs2_re_i && (id_reg2_raddr_i != '0) && pending_q[id_reg2_raddr_i]);
    waw    = id_reg_we_i && (id_reg_waddr_i != '0) && pending_q[id_reg_waddr_i];
    full   = id_long_op_i && (outstanding_q == MAX_OUT);
    hazard = id_valid_i && (raw || waw || full);
  end

  // Control FSM: flush beats drain/stall/ex_busy so the pipe loads bubbles.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    stall       = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (flush_req_i) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_DRAIN) begin
          if (outstanding_q != '0) begin
            stall = 1'b1;
          end else begin
            stall   = ex_busy_i;
            state_d = ST_RUN;
          end
        end else if (id_valid_i && id_serialize_i && (outstanding_q != '0)) begin
          stall   = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          stall = hazard || ex_busy_i;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (flush_req_i) begin
          flush_cnt_d = FLUSH_RELOAD;
        end else if (flush_cnt_q == FCNT_W'(1)) begin
          flush_cnt_d = '0;
          state_d     = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FCNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Issue and output bus; undefined bus bits stay 0.
  always_comb begin
    issue        = id_valid_i && !stall && !flush;
    stall_flag_o = '0;
    stall_flag_o[`CU_STALL] = stall;
    stall_flag_o[`CU_FLUSH] = flush;
  end

  // Scoreboard and outstanding-count next state; a same-cycle set wins over a clear.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue && id_long_op_i && id_reg_we_i && (id_reg_waddr_i != '0))
      set_mask = 32'(1) << id_reg_waddr_i;
    if (wb_long_we_i)
      clr_mask = 32'(1) << wb_long_waddr_i;
    pending_d = (pending_q & ~clr_mask) | set_mask;

    inc = issue && id_long_op_i;
    dec = wb_long_we_i && (outstanding_q != '0);
    case ({inc, dec})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    sb_busy_d = (outstanding_d != '0);
  end

  // State registers with synchronous reset; reset abandons any drain or flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the scoreboard is control state, not storage, so it must be reset.
      state_q       <= ST_RUN;
      flush_cnt_q   <= '0;
      pending_q     <= '0;
      outstanding_q <= '0;
      sb_busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      sb_busy_q     <= sb_busy_d;
    end
  end

  assign issue_o   = issue;
  assign sb_busy_o = sb_busy_q;

`ifdef HAZARD_CTRL_STAT_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] flush_cnt_stat_q, flush_cnt_stat_d;

  // Statistics: stalled valid cycles and redirect pulses, wrapping.
  always_comb begin
    stall_cnt_d      = stall_cnt_q + STAT_W'(stall && id_valid_i);
    flush_cnt_stat_d = flush_cnt_stat_q + STAT_W'(flush_req_i);
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q      <= '0;
      flush_cnt_stat_q <= '0;
    end else begin
      stall_cnt_q      <= stall_cnt_d;
      flush_cnt_stat_q <= flush_cnt_stat_d;
    end
  end

  assign stat_stall_cnt_o = stall_cnt_q;
  assign stat_flush_cnt_o = flush_cnt_stat_q;
`else
  assign stat_stall_cnt_o = {STAT_W{1'b0}};
  assign stat_flush_cnt_o = {STAT_W{1'b0}};
`endif

endmodule
